// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request and response handshake.
// Multiply is iterative shift-add; all other ops complete in one cycle.
module alu_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ip_0,
  input  logic [WIDTH-1:0] ip_1,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_0,
  output logic             change_pc,
  output logic [2:0]       flags
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpBeq = 3'd2;
  localparam logic [2:0] OpBlt = 3'd3;
  localparam logic [2:0] OpAnd = 3'd4;
  localparam logic [2:0] OpOr  = 3'd5;
  localparam logic [2:0] OpMul = 3'd6;
  localparam logic [2:0] OpXor = 3'd7;

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

  state_e              state_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [CntW-1:0]     cnt_q;

  // Single-cycle datapath, evaluated on the captured-at-accept inputs.
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH:0]      diff_ext;
  logic                add_ovf;
  logic                sub_ovf;
  logic                less;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c;
  logic                alu_v;
  logic                alu_cpc;
  logic [2*WIDTH-1:0]  acc_nxt;

  assign sum_ext  = {1'b0, ip_0} + {1'b0, ip_1};
  assign diff_ext = {1'b0, ip_0} - {1'b0, ip_1};
  assign add_ovf  = (ip_0[WIDTH-1] == ip_1[WIDTH-1]) && (sum_ext[WIDTH-1] != ip_0[WIDTH-1]);
  assign sub_ovf  = (ip_0[WIDTH-1] != ip_1[WIDTH-1]) && (diff_ext[WIDTH-1] != ip_0[WIDTH-1]);
  // Signed less-than is the difference sign corrected by overflow.
  assign less     = (SIGNED_CMP != 0) ? (diff_ext[WIDTH-1] ^ sub_ovf) : diff_ext[WIDTH];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_cpc = 1'b0;
    unique case (opcode)
      OpAdd: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_ovf;
      end
      OpSub, OpBeq, OpBlt: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = sub_ovf;
        if (opcode == OpBeq) alu_cpc = (ip_0 == ip_1);
        if (opcode == OpBlt) alu_cpc = less;
      end
      OpAnd: alu_res = ip_0 & ip_1;
      OpOr:  alu_res = ip_0 | ip_1;
      OpXor: alu_res = ip_0 ^ ip_1;
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      op_0      <= '0;
      change_pc <= 1'b0;
      flags     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (opcode == OpMul) begin
              mcand_q  <= {{WIDTH{1'b0}}, ip_0};
              mplier_q <= ip_1;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              op_0      <= alu_res;
              flags     <= {(alu_res == '0), alu_c, alu_v};
              change_pc <= alu_cpc;
              out_valid <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          // Last partial product folds straight into the registered result.
          if (cnt_q == CntLast) begin
            op_0      <= acc_nxt[WIDTH-1:0];
            flags     <= {~|acc_nxt[WIDTH-1:0], |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
            change_pc <= 1'b0;
            out_valid <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq, plus directed signed-compare and
// narrow-width multiply runs on two extra instances.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ip_0 = '0;
  logic [31:0] ip_1 = '0;
  logic [2:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op_0;
  logic        change_pc;
  logic [2:0]  flags;

  logic        s_valid = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [2:0]  s_op = '0;
  logic        s_ordy = 1'b1;
  logic        sg_ready, sg_ovalid, sg_cpc;
  logic [31:0] sg_res;
  logic [2:0]  sg_flags;
  logic        n8_ready, n8_ovalid, n8_cpc;
  logic [7:0]  n8_res;
  logic [2:0]  n8_flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SIGNED_CMP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ip_0(ip_0), .ip_1(ip_1), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .op_0(op_0), .change_pc(change_pc), .flags(flags)
  );

  alu_seq #(.WIDTH(32), .SIGNED_CMP(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(sg_ready),
    .ip_0(s_a), .ip_1(s_b), .opcode(s_op), .out_valid(sg_ovalid),
    .out_ready(s_ordy), .op_0(sg_res), .change_pc(sg_cpc), .flags(sg_flags)
  );

  alu_seq #(.WIDTH(8), .SIGNED_CMP(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(n8_ready),
    .ip_0(s_a[7:0]), .ip_1(s_b[7:0]), .opcode(s_op), .out_valid(n8_ovalid),
    .out_ready(s_ordy), .op_0(n8_res), .change_pc(n8_cpc), .flags(n8_flags)
  );

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flags;
    logic        cpc;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input bit sgn, input logic [2:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t         e;
    logic [127:0] mask, p;
    logic [63:0]  a, b, r;
    logic         sa, sb, c, v, cpc;
    mask = (128'd1 << w) - 128'd1;
    a = a_in & mask[63:0];
    b = b_in & mask[63:0];
    sa = a[w-1];
    sb = b[w-1];
    c = 1'b0; v = 1'b0; cpc = 1'b0; r = '0;
    case (op)
      3'd0: begin
        p = 128'(a) + 128'(b);
        r = 64'(p & mask);
        c = p[w];
        v = (sa == sb) && (r[w-1] != sa);
      end
      3'd1, 3'd2, 3'd3: begin
        r = 64'((128'(a) - 128'(b)) & mask);
        c = (a < b);
        v = (sa != sb) && (r[w-1] != sa);
        if (op == 3'd2) cpc = (a == b);
        if (op == 3'd3) cpc = sgn ? ((sa != sb) ? sa : (a < b)) : (a < b);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: begin
        p = 128'(a) * 128'(b);
        r = 64'(p & mask);
        c = ((p >> w) != 128'd0);
      end
      default: r = a ^ b;
    endcase
    e.res = r;
    e.flags = {(r == 64'd0), c, v};
    e.cpc = cpc;
    e.lat = (op == 3'd6) ? w + 1 : 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; junk in_valid pulses while busy must be ignored.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      ip_0 = $urandom;
      ip_1 = $urandom;
      opcode = 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    ip_0 = a;
    ip_1 = b;
    opcode = op;
    e = model(32, 1'b0, op, {32'd0, a}, {32'd0, b});
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    ip_0 = $urandom;
    ip_1 = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || !in_ready); i++) @(negedge clk);
    chk("drain queue empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on each new result, holds it for a random back-pressure window.
  logic [31:0] cur_res;
  logic [2:0]  cur_fl;
  logic        cur_cpc;
  bit          holding = 1'b0;
  bit          hs_pending = 1'b0;
  int          hold_left = 0;
  int          n_txn = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
        hs_pending = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (hs_pending) begin
          chk("out_valid low after handshake", 64'(out_valid), 64'd0);
          chk("in_ready after handshake", 64'(in_ready), 64'd1);
          hs_pending = 1'b0;
        end
        if (holding) begin
          chk("hold out_valid", 64'(out_valid), 64'd1);
          chk("hold op_0", 64'(op_0), 64'(cur_res));
          chk("hold flags", 64'(flags), 64'(cur_fl));
          chk("hold change_pc", 64'(change_pc), 64'(cur_cpc));
        end else if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected result: op_0=%0h with no request outstanding", op_0);
          end else begin
            e = exp_q.pop_front();
            chk("op_0", 64'(op_0), e.res);
            chk("flags", 64'(flags), 64'(e.flags));
            chk("change_pc", 64'(change_pc), 64'(e.cpc));
            chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            cur_res = op_0;
            cur_fl = flags;
            cur_cpc = change_pc;
            holding = 1'b1;
            hold_left = (n_txn % 4 == 0) ? 5 : int'($urandom_range(0, 3));
            n_txn++;
          end
        end
        if (holding) begin
          chk("in_ready low while busy", 64'(in_ready), 64'd0);
          if (hold_left == 0) begin
            out_ready = 1'b1;
            holding = 1'b0;
            hs_pending = 1'b1;
          end else begin
            out_ready = 1'b0;
            hold_left--;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic sec_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] sres, output logic [2:0] sfl, output logic scpc,
                         output int slat, output logic [7:0] nres, output logic [2:0] nfl,
                         output logic ncpc, output int nlat);
    bit gs = 1'b0;
    bit gn = 1'b0;
    sres = '0; sfl = '0; scpc = 1'b0; slat = -1;
    nres = '0; nfl = '0; ncpc = 1'b0; nlat = -1;
    @(negedge clk);
    chk("sec ready signed", 64'(sg_ready), 64'd1);
    chk("sec ready w8", 64'(n8_ready), 64'd1);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_op = op;
    for (int k = 1; k <= 100 && !(gs && gn); k++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (sg_ovalid && !gs) begin
        gs = 1'b1; sres = sg_res; sfl = sg_flags; scpc = sg_cpc; slat = k;
      end
      if (n8_ovalid && !gn) begin
        gn = 1'b1; nres = n8_res; nfl = n8_flags; ncpc = n8_cpc; nlat = k;
      end
    end
  endtask

  task automatic sec_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sres;
    logic [7:0]  nres;
    logic [2:0]  sfl, nfl;
    logic        scpc, ncpc;
    int          slat, nlat;
    exp_t        es, en;
    sec_run(op, a, b, sres, sfl, scpc, slat, nres, nfl, ncpc, nlat);
    es = model(32, 1'b1, op, {32'd0, a}, {32'd0, b});
    en = model(8, 1'b0, op, {32'd0, a}, {32'd0, b});
    chk("signed op_0", 64'(sres), es.res);
    chk("signed flags", 64'(sfl), 64'(es.flags));
    chk("signed change_pc", 64'(scpc), 64'(es.cpc));
    chk("signed latency", 64'(slat), 64'(es.lat));
    chk("w8 op_0", 64'(nres), en.res);
    chk("w8 flags", 64'(nfl), 64'(en.flags));
    chk("w8 change_pc", 64'(ncpc), 64'(en.cpc));
    chk("w8 latency", 64'(nlat), 64'(en.lat));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    bit          seen;

    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset op_0", 64'(op_0), 64'd0);
    chk("reset flags", 64'(flags), 64'd0);
    chk("reset change_pc", 64'(change_pc), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(3'd1, 32'd3, 32'd5);
    issue(3'd3, 32'hFFFF_FFFF, 32'd1);
    issue(3'd2, 32'd7, 32'd7);
    issue(3'd6, 32'h0001_0000, 32'h0001_0000);
    issue(3'd6, 32'd6, 32'd7);

    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      a = rnd_opnd();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_opnd();
      issue(op, a, b);
    end
    drain();

    // Asynchronous reset in the middle of a multiply.
    issue(3'd0, 32'd5, 32'd6);
    drain();
    issue(3'd6, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset op_0", 64'(op_0), 64'd0);
    chk("async reset flags", 64'(flags), 64'd0);
    chk("async reset change_pc", 64'(change_pc), 64'd0);
    chk("async reset in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset release", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no result after discarded multiply", 64'(seen), 64'd0);

    sec_check(3'd3, 32'hFFFF_FFFF, 32'd1);
    sec_check(3'd6, 32'd15, 32'd17);
    sec_check(3'd0, 32'h0000_007F, 32'd1);
    sec_check(3'd3, 32'h0000_0001, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL global timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
